// File: rtl/reflet_vga_rect_fill_pkg.sv
// Shared definitions for the reflet_VGA rectangle fill engine: FSM encodings
// and default widths, reused by other reflet_VGA feeders.
package reflet_vga_rect_fill_pkg;

  localparam int DEF_COLOR_DEPTH = 2;
  localparam int DEF_H_WIDTH     = 7;
  localparam int DEF_V_WIDTH     = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/reflet_vga_rect_walker.sv
// Raster cursor over a latched rectangle: load, step (x fastest) and a last flag.
// End detection uses equality on the current cursor, so coordinates never wrap.
module reflet_vga_rect_walker #(
  parameter int h_width = 7,
  parameter int v_width = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [h_width-1:0] x0_i,
  input  logic [h_width-1:0] x1_i,
  input  logic [v_width-1:0] y0_i,
  input  logic [v_width-1:0] y1_i,
  output logic [h_width-1:0] x_next_o,
  output logic [v_width-1:0] y_next_o,
  output logic               last_o
);

  logic [h_width-1:0] x_q, x0_q, x1_q;
  logic [v_width-1:0] y_q, y0_q, y1_q;
  logic               x_end, y_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
    end else if (load_i) begin
      x0_q <= x0_i;
      x1_q <= x1_i;
      y0_q <= y0_i;
      y1_q <= y1_i;
      x_q  <= x0_i;
      y_q  <= y0_i;
    end else if (step_i) begin
      x_q <= x_next_o;
      y_q <= y_next_o;
    end
  end

  always_comb begin
    x_end    = (x_q == x1_q);
    y_end    = (y_q == y1_q);
    last_o   = x_end && y_end;
    x_next_o = x_end ? x0_q : x_q + h_width'(1);
    y_next_o = (x_end && !y_end) ? y_q + v_width'(1) : y_q;
  end

endmodule

// File: rtl/reflet_vga_rect_fill.sv
// Rectangle fill engine feeding the reflet_VGA bitmap-write port: one command in,
// one registered pixel write per unpaused cycle, then a one-cycle done pulse.
module reflet_vga_rect_fill
  import reflet_vga_rect_fill_pkg::*;
#(
  parameter int color_depth = DEF_COLOR_DEPTH,
  parameter int h_width     = DEF_H_WIDTH,
  parameter int v_width     = DEF_V_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [h_width-1:0]     x0,
  input  logic [h_width-1:0]     x1,
  input  logic [v_width-1:0]     y0,
  input  logic [v_width-1:0]     y1,
  input  logic [color_depth-1:0] R_cmd,
  input  logic [color_depth-1:0] G_cmd,
  input  logic [color_depth-1:0] B_cmd,
  input  logic                   pause,
  output logic                   write_bitmap,
  output logic [h_width-1:0]     h_pixel,
  output logic [v_width-1:0]     v_pixel,
  output logic [color_depth-1:0] R_out,
  output logic [color_depth-1:0] G_out,
  output logic [color_depth-1:0] B_out,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state_o
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE.

  fill_state_e state_q, state_d;

  logic                   accept, rect_ok, step, last;
  logic [h_width-1:0]     x_next;
  logic [v_width-1:0]     y_next;

  logic                   write_q, write_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic [h_width-1:0]     h_q, h_d;
  logic [v_width-1:0]     v_q, v_d;
  logic [color_depth-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  always_comb begin
    accept  = (state_q == ST_IDLE) && cmd_valid;
    rect_ok = (x0 <= x1) && (y0 <= y1);
    // The first pixel is written straight from the command on the accepting edge,
    // so a FILL cycle only steps while the displayed pixel is not the last one.
    step    = (state_q == ST_FILL) && !pause && !last;
  end

  reflet_vga_rect_walker #(
    .h_width (h_width),
    .v_width (v_width)
  ) u_walker (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept),
    .step_i   (step),
    .x0_i     (x0),
    .x1_i     (x1),
    .y0_i     (y0),
    .y1_i     (y1),
    .x_next_o (x_next),
    .y_next_o (y_next),
    .last_o   (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = rect_ok ? ST_FILL : ST_DONE;
      ST_FILL: if (!pause && last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    write_d = (accept && rect_ok) || step;
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
    h_d     = h_q;
    v_d     = v_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    if (accept) begin
      r_d = R_cmd;
      g_d = G_cmd;
      b_d = B_cmd;
    end
    if (accept && rect_ok) begin
      h_d = x0;
      v_d = y0;
    end else if (step) begin
      h_d = x_next;
      v_d = y_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      h_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      write_q <= write_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      h_q     <= h_d;
      v_q     <= v_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign write_bitmap = write_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign h_pixel      = h_q;
  assign v_pixel      = v_q;
  assign R_out        = r_q;
  assign G_out        = g_q;
  assign B_out        = b_q;
  assign dbg_state_o  = state_q;

endmodule
